down_count_monitor: RTL

//  Downstream checker for the 4-bit synchronous down counter. Samples the counter

---
 rtl/down_count_monitor_pkg.sv | 19 +
 rtl/down_count_monitor_sat_counter.sv | 59 +++++
 rtl/down_count_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/down_count_monitor_pkg.sv
// ---------------------------------------------------------------------------
// down_mon_pkg
//   Shared definitions for the down-counter monitor:
//     - state_t        : monitor FSM encoding (IDLE / TRACK / ERROR)
//     - DEF_WIDTH      : default width of the monitored count bus
//     - DEF_WRAP_CNT_W : default width of the wrap event counter
// ---------------------------------------------------------------------------
package down_mon_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_WRAP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

endpackage : down_mon_pkg

// File: rtl/down_count_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   W-bit up counter that saturates at all-ones, with a sticky saturation
//   flag. Both count and flag are registered and cleared together.
//
// Ports
//   clk   in   1   system clock, rising edge
//   rst   in   1   asynchronous, active-low reset
//   clr   in   1   synchronous clear (priority over inc)
//   inc   in   1   increment request
//   cnt   out  W   current count
//   sat   out  1   sticky: count has reached all-ones
// ---------------------------------------------------------------------------
module sat_counter
  import down_mon_pkg::*;
#(
  parameter int W = DEF_WRAP_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc && (cnt_q != '1)) begin
        cnt_d = cnt_q + W'(1);
      end
      // Flag follows the next count so it asserts in the same cycle the
      // count first reads all-ones.
      sat_d = sat_q | (cnt_d == '1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule : sat_counter

// File: rtl/down_count_monitor.sv
// ---------------------------------------------------------------------------
// down_count_monitor
//   Checks the output of a synchronous down counter. Every valid sample must
//   be a decrement (mod 2^WIDTH) or a hold of the previous sample. Wraps
//   (0 -> all-ones) are pulsed and counted; illegal steps are flagged.
//   All outputs are registered: one cycle after the qualifying sample.
//
// Build option
//   MON_STEP_CHECK_EN : when defined, illegal steps raise step_err and
//                       err_sticky and move the FSM into ERROR. When not
//                       defined, the FSM only uses IDLE/TRACK and both error
//                       outputs stay 0; wrap detection is unaffected.
//
// Ports
//   clk         in   1           system clock, rising edge
//   rst         in   1           asynchronous, active-low reset
//   count_in    in   WIDTH       counter value under observation
//   count_vld   in   1           count_in is a fresh sample this cycle
//   clr         in   1           synchronous clear of state and statistics
//   wrap_pulse  out  1           one-cycle pulse per detected wrap
//   wrap_cnt    out  WRAP_CNT_W  wraps since reset/clr (saturating)
//   wrap_sat    out  1           sticky: wrap_cnt reached all-ones
//   step_err    out  1           one-cycle pulse on an illegal step
//   err_sticky  out  1           sticky: any illegal step since reset/clr
// ---------------------------------------------------------------------------
module down_count_monitor
  import down_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int WRAP_CNT_W = DEF_WRAP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  count_vld,
  input  logic                  clr,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic                  wrap_sat,
  output logic                  step_err,
  output logic                  err_sticky
);

`ifdef MON_STEP_CHECK_EN
  localparam bit STEP_CHECK_EN = 1'b1;
`else
  localparam bit STEP_CHECK_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             step_err_q, step_err_d;
  logic             err_sticky_q, err_sticky_d;

  logic [WIDTH-1:0] exp_val;
  logic             is_dec;
  logic             is_hold;
  logic             is_wrap;
  logic             wrap_inc;

  // A decrement from zero can only land on all-ones, so a decrement with
  // prev==0 is exactly the wrap event.
  assign exp_val = prev_q - WIDTH'(1);
  assign is_dec  = (count_in == exp_val);
  assign is_hold = (count_in == prev_q);
  assign is_wrap = is_dec && (prev_q == '0);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_pulse_d = 1'b0;
    step_err_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    wrap_inc     = 1'b0;

    if (clr) begin
      // Clear wins over a simultaneous sample; that sample is dropped.
      state_d      = IDLE;
      prev_d       = '0;
      err_sticky_d = 1'b0;
    end else if (count_vld) begin
      prev_d = count_in;
      unique case (state_q)
        IDLE: begin
          // First sample only seeds prev; nothing to compare against yet.
          state_d = TRACK;
        end
        TRACK, ERROR: begin
          wrap_inc     = is_wrap;
          wrap_pulse_d = is_wrap;
          if (STEP_CHECK_EN && (state_q == TRACK) && !is_dec && !is_hold) begin
            step_err_d   = 1'b1;
            err_sticky_d = 1'b1;
            state_d      = ERROR;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      wrap_pulse_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      wrap_pulse_q <= wrap_pulse_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  sat_counter #(
    .W (WRAP_CNT_W)
  ) u_wrap_counter (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wrap_inc),
    .cnt (wrap_cnt),
    .sat (wrap_sat)
  );

  assign wrap_pulse = wrap_pulse_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;

endmodule : down_count_monitor
